fpu_addsub_arbiter: RTL and testbench

- Two-port round-robin arbiter and sequencer that shares one FPU_Add_Subtract_Function instance between two requesters (e.g. the CORDIC X and Y update channels).
- Accepts a request with its operands and drives the FPU beg/ack handshake.
- Returns the IEEE result and flags to the winning requester with a one-cycle done pulse.
- Adds a watchdog so a hung FPU cannot deadlock the requesters.

---
 rtl/fpu_addsub_arbiter.sv | 163 ++++++++++++++++
 tb/tb_fpu_addsub_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_addsub_arbiter.sv
// Round-robin arbiter/sequencer sharing one FPU add/subtract unit between two requesters.
// Drives the FPU beg/ack handshake and aborts a hung operation after TIMEOUT cycles.
module fpu_addsub_arbiter #(
  parameter int unsigned W       = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_0,
  input  logic         req_1,
  input  logic [W-1:0] data_x_0,
  input  logic [W-1:0] data_y_0,
  input  logic [W-1:0] data_x_1,
  input  logic [W-1:0] data_y_1,
  input  logic         add_subt_0,
  input  logic         add_subt_1,
  input  logic [1:0]   r_mode_0,
  input  logic [1:0]   r_mode_1,
  output logic         gnt_0,
  output logic         gnt_1,
  output logic         done_0,
  output logic         done_1,
  output logic [W-1:0] result,
  output logic         overflow,
  output logic         underflow,
  output logic         timeout_err,
  output logic         busy,
  output logic         fpu_beg,
  output logic         fpu_ack,
  output logic [W-1:0] fpu_data_x,
  output logic [W-1:0] fpu_data_y,
  output logic         fpu_add_subt,
  output logic [1:0]   fpu_r_mode,
  input  logic         fpu_ready,
  input  logic         fpu_overflow,
  input  logic         fpu_underflow,
  input  logic [W-1:0] fpu_result
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StWait,
    StAck
  } state_e;

  state_e          state_q, state_d;
  logic            last_gnt_q, last_gnt_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            grant;
  logic            grant_port;
  logic            cap_res;
  logic            cap_tmo;

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    grant      = 1'b0;
    grant_port = 1'b0;
    cap_res    = 1'b0;
    cap_tmo    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_0 || req_1) begin
          grant      = 1'b1;
          // On a tie the port that was not served last wins.
          grant_port = (req_0 && req_1) ? ~last_gnt_q : req_1;
          last_gnt_d = grant_port;
          state_d    = StLoad;
        end
      end
      StLoad: begin
        state_d = StStart;
      end
      StStart: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        if (fpu_ready) begin
          cap_res = 1'b1;
          done_d  = 1'b1;
          state_d = StAck;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          cap_tmo = 1'b1;
          done_d  = 1'b1;
          state_d = StAck;
        end
      end
      StAck: begin
        // An aborted operation does not wait for the FPU to release ready.
        if (timeout_err || !fpu_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      last_gnt_q <= 1'b1;
      cnt_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpu_data_x   <= '0;
      fpu_data_y   <= '0;
      fpu_add_subt <= 1'b0;
      fpu_r_mode   <= 2'b00;
      result       <= '0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      if (grant) begin
        fpu_data_x   <= grant_port ? data_x_1   : data_x_0;
        fpu_data_y   <= grant_port ? data_y_1   : data_y_0;
        fpu_add_subt <= grant_port ? add_subt_1 : add_subt_0;
        fpu_r_mode   <= grant_port ? r_mode_1   : r_mode_0;
      end
      if (cap_res) begin
        result      <= fpu_result;
        overflow    <= fpu_overflow;
        underflow   <= fpu_underflow;
        timeout_err <= 1'b0;
      end else if (cap_tmo) begin
        result      <= '0;
        overflow    <= 1'b0;
        underflow   <= 1'b0;
        timeout_err <= 1'b1;
      end
    end
  end

  // last_gnt_q doubles as the owner of the operation in flight.
  assign gnt_0   = (state_q == StLoad) && !last_gnt_q;
  assign gnt_1   = (state_q == StLoad) && last_gnt_q;
  assign done_0  = done_q && !last_gnt_q;
  assign done_1  = done_q && last_gnt_q;
  assign fpu_beg = (state_q == StStart);
  assign fpu_ack = (state_q == StAck);
  assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// Randomized bench for fpu_addsub_arbiter with an in-bench FPU stub and a
// transaction-level round-robin / handshake reference model.
module tb_fpu_addsub_arbiter;

  localparam int unsigned W       = 32;
  localparam int unsigned TIMEOUT = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_0, req_1;
  logic [W-1:0] data_x_0, data_y_0, data_x_1, data_y_1;
  logic         add_subt_0, add_subt_1;
  logic [1:0]   r_mode_0, r_mode_1;
  logic         gnt_0, gnt_1, done_0, done_1;
  logic [W-1:0] result;
  logic         overflow, underflow, timeout_err, busy, fpu_beg, fpu_ack;
  logic [W-1:0] fpu_data_x, fpu_data_y;
  logic         fpu_add_subt;
  logic [1:0]   fpu_r_mode;
  logic         fpu_ready, fpu_overflow, fpu_underflow;
  logic [W-1:0] fpu_result;

  always #5 clk = ~clk;

  fpu_addsub_arbiter #(
    .W      (W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_0        (req_0),
    .req_1        (req_1),
    .data_x_0     (data_x_0),
    .data_y_0     (data_y_0),
    .data_x_1     (data_x_1),
    .data_y_1     (data_y_1),
    .add_subt_0   (add_subt_0),
    .add_subt_1   (add_subt_1),
    .r_mode_0     (r_mode_0),
    .r_mode_1     (r_mode_1),
    .gnt_0        (gnt_0),
    .gnt_1        (gnt_1),
    .done_0       (done_0),
    .done_1       (done_1),
    .result       (result),
    .overflow     (overflow),
    .underflow    (underflow),
    .timeout_err  (timeout_err),
    .busy         (busy),
    .fpu_beg      (fpu_beg),
    .fpu_ack      (fpu_ack),
    .fpu_data_x   (fpu_data_x),
    .fpu_data_y   (fpu_data_y),
    .fpu_add_subt (fpu_add_subt),
    .fpu_r_mode   (fpu_r_mode),
    .fpu_ready    (fpu_ready),
    .fpu_overflow (fpu_overflow),
    .fpu_underflow(fpu_underflow),
    .fpu_result   (fpu_result)
  );

  int n_vec = 0;
  int n_err = 0;
  int last_port = 1;

  // Per-port pending operation: operands plus how the FPU stub will respond.
  logic [W-1:0] ox [2];
  logic [W-1:0] oy [2];
  logic         os [2];
  logic [1:0]   orm [2];
  int           olat [2];
  int           ohold [2];  // 0 = FPU never answers
  logic         oovf [2];
  logic         ounf [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Single-precision <-> real for normal numbers and zero; mantissa truncated.
  function automatic real s2r(input logic [31:0] s);
    logic [63:0] d;
    if (s[30:0] == 31'd0) return 0.0;
    d = {s[31], 11'(int'(s[30:23]) + 896), s[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    return {d[63], 8'(int'(d[62:52]) - 896), d[51:29]};
  endfunction

  function automatic logic [31:0] fpu_func(input logic [31:0] x, input logic [31:0] y,
                                           input logic sub);
    return sub ? r2s(s2r(x) - s2r(y)) : r2s(s2r(x) + s2r(y));
  endfunction

  function automatic logic [31:0] rand_float();
    return {1'($urandom_range(1, 0)), 8'($urandom_range(134, 120)), 23'($urandom)};
  endfunction

  task automatic rand_op(input int p);
    ox[p]    = rand_float();
    oy[p]    = rand_float();
    os[p]    = 1'($urandom);
    orm[p]   = 2'($urandom);
    olat[p]  = int'($urandom_range(TIMEOUT, 1));
    ohold[p] = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(4, 1));
    oovf[p]  = 1'($urandom);
    ounf[p]  = 1'($urandom);
  endtask

  task automatic fpu_idle();
    fpu_ready     = 1'b0;
    fpu_overflow  = 1'b0;
    fpu_underflow = 1'b0;
    fpu_result    = W'($urandom);
  endtask

  task automatic present(input bit r0, input bit r1);
    data_x_0   = ox[0];
    data_y_0   = oy[0];
    add_subt_0 = os[0];
    r_mode_0   = orm[0];
    data_x_1   = ox[1];
    data_y_1   = oy[1];
    add_subt_1 = os[1];
    r_mode_1   = orm[1];
    req_0      = r0;
    req_1      = r1;
  endtask

  task automatic check_reset_outputs();
    check("rst_ctl", 64'({gnt_0, gnt_1, done_0, done_1, overflow, underflow, timeout_err, busy,
                          fpu_beg, fpu_ack, fpu_add_subt, fpu_r_mode}), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_fpu_data", {fpu_data_x, fpu_data_y}, 64'(0));
  endtask

  // Called at a negedge with the arbiter idle (or about to be) and port p's request pending.
  task automatic serve(input int p);
    int          cyc;
    logic [33:0] exp_res;
    @(negedge clk);
    cyc = 0;
    while (!(gnt_0 || gnt_1) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("gnt_latency", 64'(cyc), 64'(0));
    check("gnt_port", 64'({gnt_1, gnt_0}), 64'({p == 1, p == 0}));
    check("fpu_operands", {fpu_data_x, fpu_data_y}, {ox[p], oy[p]});
    check("fpu_op_mode", 64'({fpu_add_subt, fpu_r_mode}), 64'({os[p], orm[p]}));
    last_port = p;
    if (p == 0) req_0 = 1'b0;
    else        req_1 = 1'b0;
    @(negedge clk);
    check("beg", 64'({fpu_beg, busy, gnt_0, gnt_1}), 64'(4'b1100));
    if (ohold[p] == 0) begin
      for (int k = 0; k < int'(TIMEOUT); k++) begin
        @(negedge clk);
        check("wait_quiet", 64'({fpu_beg, done_0, done_1, fpu_ack, gnt_0, gnt_1}), 64'(0));
      end
      @(negedge clk);
      check("tmo_done", 64'({done_1, done_0, fpu_ack, timeout_err}),
            64'({p == 1, p == 0, 1'b1, 1'b1}));
      check("tmo_result", 64'({result, overflow, underflow}), 64'(0));
      exp_res = '0;
    end else begin
      for (int k = 0; k < olat[p]; k++) begin
        @(negedge clk);
        check("wait_quiet", 64'({fpu_beg, done_0, done_1, fpu_ack, gnt_0, gnt_1}), 64'(0));
      end
      fpu_ready     = 1'b1;
      fpu_result    = fpu_func(fpu_data_x, fpu_data_y, fpu_add_subt);
      fpu_overflow  = oovf[p];
      fpu_underflow = ounf[p];
      exp_res       = {fpu_func(ox[p], oy[p], os[p]), oovf[p], ounf[p]};
      @(negedge clk);
      check("done", 64'({done_1, done_0, fpu_ack, timeout_err}),
            64'({p == 1, p == 0, 1'b1, 1'b0}));
      check("result", 64'({result, overflow, underflow}), 64'(exp_res));
      for (int k = 1; k < ohold[p]; k++) begin
        @(negedge clk);
        check("ack_hold", 64'({fpu_ack, busy, done_0, done_1}), 64'(4'b1100));
      end
      fpu_idle();
    end
    @(negedge clk);
    check("ack_exit", 64'({fpu_ack, busy, done_0, done_1}), 64'(0));
    check("result_hold", 64'({result, overflow, underflow}), 64'(exp_res));
  endtask

  // Round-robin reference: on a tie the port not served last goes first.
  task automatic round(input bit r0, input bit r1);
    int first;
    present(r0, r1);
    if (r0 && r1) begin
      first = 1 - last_port;
      serve(first);
      serve(1 - first);
    end else begin
      serve(r0 ? 0 : 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b0;
    for (int p = 0; p < 2; p++) rand_op(p);
    present(1'b0, 1'b0);
    fpu_idle();
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Simultaneous requests right after reset: 0, 1, 0, 1.
    repeat (2) begin
      rand_op(0);
      rand_op(1);
      ohold[0] = 1;
      ohold[1] = 1;
      round(1'b1, 1'b1);
    end

    // Single request 1.0 + 2.0.
    ox[0] = 32'h3F80_0000; oy[0] = 32'h4000_0000; os[0] = 1'b0; orm[0] = 2'd0;
    olat[0] = 6; ohold[0] = 1; oovf[0] = 1'b0; ounf[0] = 1'b0;
    round(1'b1, 1'b0);
    check("one_plus_two", 64'(result), 64'(32'h4040_0000));

    // Subtract to zero with forced overflow, then overflow clears on the next done.
    ox[1] = 32'h4000_0000; oy[1] = 32'h4000_0000; os[1] = 1'b1; orm[1] = 2'd1;
    olat[1] = 3; ohold[1] = 1; oovf[1] = 1'b1; ounf[1] = 1'b0;
    round(1'b0, 1'b1);
    check("sub_zero", 64'({result, overflow}), 64'({32'h0, 1'b1}));
    rand_op(1);
    oovf[1] = 1'b0;
    ohold[1] = 1;
    round(1'b0, 1'b1);
    check("ovf_cleared", 64'(overflow), 64'(0));

    // Hung FPU, then the next request is still served.
    rand_op(0);
    ohold[0] = 0;
    round(1'b1, 1'b0);
    check("tmo_flag_held", 64'(timeout_err), 64'(1));
    rand_op(1);
    ohold[1] = 2;
    round(1'b0, 1'b1);

    // Ready held for five cycles; latency at the timeout boundary.
    rand_op(0);
    olat[0] = 4;
    ohold[0] = 5;
    round(1'b1, 1'b0);
    rand_op(1);
    olat[1] = TIMEOUT;
    ohold[1] = 1;
    round(1'b0, 1'b1);

    // Asynchronous reset while waiting on the FPU.
    rand_op(0);
    present(1'b1, 1'b0);
    @(negedge clk);
    req_0 = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1 check_reset_outputs();
    @(negedge clk);
    rst = 1'b1;
    last_port = 1;
    repeat (3) begin
      @(negedge clk);
      check("no_done_after_rst", 64'({done_0, done_1, busy}), 64'(0));
    end
    rand_op(0);
    rand_op(1);
    round(1'b1, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      int pat;
      rand_op(0);
      rand_op(1);
      pat = int'($urandom_range(3, 1));
      round(pat[0], pat[1]);
      repeat ($urandom_range(2, 0)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
